// File: rtl/branch_resolve_queue_pkg.sv
// Shared encodings for the GHT/IJTC update interface and the branch resolve queue.
// Action fields and checkpoint width match the GlobalHistoryTable consumer.
package branch_resolve_queue_pkg;

  localparam int SINGLE_WORD        = 32;
  localparam int GHT_CHECKPOINT_LEN = 36;  // {dest[31:2], ghr[3:0], counter[1:0]}

  typedef enum logic [1:0] {
    PHT_IDLE    = 2'd0,
    PHT_DIRECT  = 2'd1,
    PHT_REPAIRE = 2'd2
  } pht_action_e;

  typedef enum logic [1:0] {
    IJTC_IDLE    = 2'd0,
    IJTC_DIRECT  = 2'd1,
    IJTC_REPAIRE = 2'd2
  } ijtc_action_e;

  typedef struct packed {
    logic         need_repair;
    pht_action_e  pht_action;
    ijtc_action_e ijtc_action;
  } repair_action_t;

  localparam int REPAIR_ACTION_W = $bits(repair_action_t);

  // A not-taken branch only mispredicts on direction; a taken one also on target.
  function automatic logic is_mispredict(
    input logic                   pred_take,
    input logic [SINGLE_WORD-1:0] pred_dest,
    input logic                   take,
    input logic [SINGLE_WORD-1:0] dest
  );
    return (take != pred_take) | (take & (dest != pred_dest));
  endfunction

endpackage

// File: rtl/brq_entry_ram.sv
// Entry storage for the branch resolve queue: one write port, async read of the head entry.
// Write lands on the clock edge; read is combinational, so no backpressure is involved here.
module brq_entry_ram #(
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 101,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches resolved against the backend; emits one registered
// GHT/IJTC update 1 cycle after each resolve. enq_ready drops when full; resolve never frees a slot same-cycle.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CKPT_W = GHT_CHECKPOINT_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enq_valid_i,
  output logic                    enq_ready_o,
  input  logic [SINGLE_WORD-1:0]  enq_vAddr_i,
  input  logic [CKPT_W-1:0]       enq_checkPoint_i,
  input  logic                    enq_predTake_i,
  input  logic [SINGLE_WORD-1:0]  enq_predDest_i,
  input  logic                    res_valid_i,
  input  logic                    res_take_i,
  input  logic [SINGLE_WORD-1:0]  res_dest_i,
  input  logic                    flush_i,
  output repair_action_t          FU_repairAction_o,
  output logic [CKPT_W-1:0]       FU_allCheckPoint_o,
  output logic [SINGLE_WORD-1:0]  FU_erroVAddr_o,
  output logic                    FU_correctTake_o,
  output logic [SINGLE_WORD-1:0]  FU_correctDest_o,
  output logic                    mispredict_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW      = $clog2(DEPTH);
  localparam int PW      = AW + 1;
  localparam int ENTRY_W = SINGLE_WORD + CKPT_W + 1 + SINGLE_WORD;

  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic                   empty, full;
  logic                   do_enq, do_res, mispredict;
  logic [ENTRY_W-1:0]     wr_entry, rd_entry;
  logic [SINGLE_WORD-1:0] head_vaddr, head_pred_dest;
  logic [CKPT_W-1:0]      head_ckpt;
  logic                   head_pred_take;

  assign empty       = (rd_ptr == wr_ptr);
  assign full        = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
  assign enq_ready_o = ~full & ~rst;
  assign count_o     = wr_ptr - rd_ptr;

  assign wr_entry = {enq_vAddr_i, enq_checkPoint_i, enq_predTake_i, enq_predDest_i};
  assign {head_vaddr, head_ckpt, head_pred_take, head_pred_dest} = rd_entry;

  // Flush outranks resolve; a mispredict squashes the same-cycle enqueue as wrong-path.
  assign do_res     = res_valid_i & ~empty & ~flush_i & ~rst;
  assign mispredict = do_res & is_mispredict(head_pred_take, head_pred_dest, res_take_i, res_dest_i);
  assign do_enq     = enq_valid_i & enq_ready_o & ~flush_i & ~mispredict;

  brq_entry_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (ENTRY_W),
    .ADDR_W (AW)
  ) u_entry_ram (
    .clk   (clk),
    .we    (do_enq),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush_i) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (do_enq) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (mispredict) begin
        rd_ptr <= wr_ptr;
      end else if (do_res) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Data fields hold between updates; only need_repair and mispredict_o pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      FU_repairAction_o  <= '0;
      FU_allCheckPoint_o <= '0;
      FU_erroVAddr_o     <= '0;
      FU_correctTake_o   <= 1'b0;
      FU_correctDest_o   <= '0;
      mispredict_o       <= 1'b0;
    end else begin
      FU_repairAction_o.need_repair <= do_res;
      mispredict_o                  <= mispredict;
      if (do_res) begin
        FU_repairAction_o.pht_action  <= mispredict ? PHT_REPAIRE : PHT_DIRECT;
        FU_repairAction_o.ijtc_action <= mispredict ? IJTC_REPAIRE : IJTC_DIRECT;
        FU_allCheckPoint_o            <= head_ckpt;
        FU_erroVAddr_o                <= head_vaddr;
        FU_correctTake_o              <= res_take_i;
        FU_correctDest_o              <= res_take_i ? res_dest_i : head_vaddr + 32'd8;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed cycles feed a model-driven scoreboard,
// an independent negedge monitor checks every emitted update.
module tb_branch_resolve_queue;
  import branch_resolve_queue_pkg::*;

  localparam int DEPTH  = 8;
  localparam int CKPT_W = 36;

  logic                clk = 1'b0;
  logic                rst;
  logic                enq_valid_i;
  logic                enq_ready_o;
  logic [31:0]         enq_vAddr_i;
  logic [CKPT_W-1:0]   enq_checkPoint_i;
  logic                enq_predTake_i;
  logic [31:0]         enq_predDest_i;
  logic                res_valid_i;
  logic                res_take_i;
  logic [31:0]         res_dest_i;
  logic                flush_i;
  repair_action_t      FU_repairAction_o;
  logic [CKPT_W-1:0]   FU_allCheckPoint_o;
  logic [31:0]         FU_erroVAddr_o;
  logic                FU_correctTake_o;
  logic [31:0]         FU_correctDest_o;
  logic                mispredict_o;
  logic [3:0]          count_o;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(DEPTH), .CKPT_W(CKPT_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .enq_valid_i        (enq_valid_i),
    .enq_ready_o        (enq_ready_o),
    .enq_vAddr_i        (enq_vAddr_i),
    .enq_checkPoint_i   (enq_checkPoint_i),
    .enq_predTake_i     (enq_predTake_i),
    .enq_predDest_i     (enq_predDest_i),
    .res_valid_i        (res_valid_i),
    .res_take_i         (res_take_i),
    .res_dest_i         (res_dest_i),
    .flush_i            (flush_i),
    .FU_repairAction_o  (FU_repairAction_o),
    .FU_allCheckPoint_o (FU_allCheckPoint_o),
    .FU_erroVAddr_o     (FU_erroVAddr_o),
    .FU_correctTake_o   (FU_correctTake_o),
    .FU_correctDest_o   (FU_correctDest_o),
    .mispredict_o       (mispredict_o),
    .count_o            (count_o)
  );

  typedef struct packed {
    logic              mis;
    logic [31:0]       pc;
    logic [CKPT_W-1:0] ckpt;
    logic              take;
    logic [31:0]       dest;
  } upd_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic [CKPT_W-1:0] ckpt;
    logic              ptake;
    logic [31:0]       pdest;
  } ent_t;

  upd_t exp_q[$];
  ent_t mdl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [CKPT_W-1:0] ckpt_of(input logic [31:0] pc);
    return {4'h5, pc ^ 32'h00A5_0000};
  endfunction

  // One clock of stimulus; the model decides what the DUT must accept and emit.
  task automatic cyc(input logic enq, input logic [31:0] pc, input logic ptake, input logic [31:0] pdest,
                     input logic res, input logic rtake, input logic [31:0] rdest, input logic flush);
    ent_t h;
    ent_t n;
    upd_t u;
    logic acc;
    logic m;
    enq_valid_i      = enq;
    enq_vAddr_i      = pc;
    enq_checkPoint_i = ckpt_of(pc);
    enq_predTake_i   = ptake;
    enq_predDest_i   = pdest;
    res_valid_i      = res;
    res_take_i       = rtake;
    res_dest_i       = rdest;
    flush_i          = flush;
    if (enq) check("enq_ready", enq_ready_o, mdl.size() < DEPTH);
    acc = enq && (mdl.size() < DEPTH);
    if (flush) begin
      mdl.delete();
      acc = 1'b0;
    end else if (res) begin
      if (mdl.size() == 0) begin
        total++;
        bad++;
        $display("FAIL res_on_empty: got res_valid with empty queue, want none");
      end else begin
        h = mdl.pop_front();
        m = (rtake != h.ptake) || (rtake && (rdest != h.pdest));
        u.mis  = m;
        u.pc   = h.pc;
        u.ckpt = h.ckpt;
        u.take = rtake;
        u.dest = rtake ? rdest : h.pc + 32'd8;
        exp_q.push_back(u);
        if (m) begin
          mdl.delete();
          acc = 1'b0;
        end
      end
    end
    if (acc) begin
      n.pc    = pc;
      n.ckpt  = ckpt_of(pc);
      n.ptake = ptake;
      n.pdest = pdest;
      mdl.push_back(n);
    end
    @(posedge clk);
    #1;
    enq_valid_i = 1'b0;
    res_valid_i = 1'b0;
    flush_i     = 1'b0;
  endtask

  // Monitor: every NEED_REPAIR pulse must match the oldest expected update.
  initial begin
    upd_t e;
    logic [105:0] act, req;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (FU_repairAction_o.need_repair === 1'b1) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_update: got pc=%h mis=%b, want no update", FU_erroVAddr_o, mispredict_o);
          end else begin
            e   = exp_q.pop_front();
            act = {mispredict_o, FU_repairAction_o.pht_action, FU_repairAction_o.ijtc_action,
                   FU_erroVAddr_o, FU_allCheckPoint_o, FU_correctTake_o, FU_correctDest_o};
            req = {e.mis, e.mis ? PHT_REPAIRE : PHT_DIRECT, e.mis ? IJTC_REPAIRE : IJTC_DIRECT,
                   e.pc, e.ckpt, e.take, e.dest};
            if (act !== req) begin
              bad++;
              $display("FAIL update: got %h want %h", act, req);
            end
          end
        end else begin
          check("idle_mispredict", mispredict_o, 1'b0);
        end
      end
    end
  end

  initial begin
    logic [31:0] pc;
    logic        pt, rt;
    logic [31:0] pd, rd;
    rst = 1'b1;
    enq_valid_i = 1'b0; enq_vAddr_i = '0; enq_checkPoint_i = '0; enq_predTake_i = 1'b0;
    enq_predDest_i = '0; res_valid_i = 1'b0; res_take_i = 1'b0; res_dest_i = '0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ready_in_rst", enq_ready_o, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_count", count_o, 4'd0);
    check("rst_need_repair", FU_repairAction_o.need_repair, 1'b0);
    check("rst_erro_vaddr", FU_erroVAddr_o, 32'h0);
    check("rst_correct_dest", FU_correctDest_o, 32'h0);
    check("rst_ready", enq_ready_o, 1'b1);

    // 1: three enqueues, no resolve
    cyc(1, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0);
    cyc(1, 32'h104, 0, 32'h0, 0, 0, 32'h0, 0);
    cyc(1, 32'h108, 0, 32'h0, 0, 0, 32'h0, 0);
    check("t1_count", count_o, 4'd3);
    check("t1_ready", enq_ready_o, 1'b1);
    cyc(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 1);
    check("t1_flush_count", count_o, 4'd0);

    // 2: correct taken prediction
    cyc(1, 32'h200, 1, 32'h400, 0, 0, 32'h0, 0);
    cyc(0, 32'h0, 0, 32'h0, 1, 1, 32'h400, 0);
    check("t2_count", count_o, 4'd0);
    check("t2_vaddr", FU_erroVAddr_o, 32'h200);
    check("t2_pht", FU_repairAction_o.pht_action, PHT_DIRECT);
    check("t2_mis", mispredict_o, 1'b0);

    // 3: target mispredict with concurrent enqueue
    cyc(1, 32'h300, 1, 32'h480, 0, 0, 32'h0, 0);
    cyc(1, 32'h304, 0, 32'h0,   0, 0, 32'h0, 0);
    cyc(1, 32'h308, 0, 32'h0,   0, 0, 32'h0, 0);
    cyc(1, 32'h30c, 0, 32'h0,   0, 0, 32'h0, 0);
    cyc(1, 32'h310, 0, 32'h0,   1, 1, 32'h500, 0);
    check("t3_count", count_o, 4'd0);
    check("t3_mis", mispredict_o, 1'b1);
    check("t3_dest", FU_correctDest_o, 32'h500);
    check("t3_ijtc", FU_repairAction_o.ijtc_action, IJTC_REPAIRE);
    cyc(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
    check("t3_dropped", count_o, 4'd0);

    // 4: fill, then enq+res while full
    for (int i = 0; i < DEPTH; i++) cyc(1, 32'h400 + 32'(4 * i), 0, 32'h0, 0, 0, 32'h0, 0);
    check("t4_full_count", count_o, 4'd8);
    check("t4_full_ready", enq_ready_o, 1'b0);
    cyc(1, 32'h500, 0, 32'h0, 1, 0, 32'h777, 0);
    check("t4_count", count_o, 4'd7);
    check("t4_nt_dest", FU_correctDest_o, 32'h408);

    // 5: flush beats a mispredicting resolve
    cyc(1, 32'h600, 0, 32'h0, 1, 1, 32'h999, 1);
    check("t5_count", count_o, 4'd0);
    check("t5_need_repair", FU_repairAction_o.need_repair, 1'b0);
    check("t5_mis", mispredict_o, 1'b0);

    // 6: streaming pairs across pointer wrap, then reset mid-stream
    pc = 32'h2000;
    for (int i = 0; i < 22; i++) begin
      pt = 1'($urandom_range(0, 1));
      pd = 32'h1000 + 32'($urandom_range(0, 3) << 2);
      rt = ($urandom_range(0, 4) == 0) ? ~pt : pt;
      rd = ($urandom_range(0, 4) == 0) ? pd + 32'd4 : pd;
      cyc(1, pc, pt, pd, (i >= 2) && (mdl.size() > 0), rt, rd, 0);
      check("t6_count", count_o, 4'(mdl.size()));
      pc = pc + 32'd4;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, pc, 0, 32'h0, 0, 0, 32'h0, 0);
      pc = pc + 32'd4;
    end
    rst = 1'b1;
    #1;
    check("t6_ready_in_rst", enq_ready_o, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mdl.delete();
    check("t6_rst_count", count_o, 4'd0);

    repeat (3) @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
